// File: rtl/md_unit.sv
// -----------------------------------------------------------------------------
// md_unit -- multiply / divide unit owning the HI and LO registers.
//
// A mult/multu/div/divu computes its full result in the cycle it is accepted
// and parks it in the pending registers. A down-counter then models the
// latency of the operation. HI/LO only take the pending values on the edge
// where the counter reaches zero, so mfhi/mflo never observe a result early.
// mthi/mtlo write HI/LO directly and never raise busy.
//
// Ports
//   clk    in   1   single clock, all state updates on the rising edge
//   reset  in   1   asynchronous, active-high; clears all state
//   start  in   1   issue strobe; md_op/a/b are sampled when high
//   md_op  in   3   0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo,
//                   7 reserved (treated as none)
//   a      in   32  rs operand (dividend / multiplicand / mthi-mtlo source)
//   b      in   32  rt operand (divisor / multiplier)
//   busy   out  1   high while a mult/div is in flight
//   hi     out  32  committed HI register
//   lo     out  32  committed LO register
//
// Parameters
//   MULT_CYCLES  busy duration for mult/multu (must be >= 1)
//   DIV_CYCLES   busy duration for div/divu   (must be >= 1)
// -----------------------------------------------------------------------------
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    // Operation encodings.
    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [2:0] OP_RSVD  = 3'd7;

    // Counter is at least 4 bits and wide enough for the longer latency.
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_BITS   = $clog2(MAX_CYCLES + 1);
    localparam int CNT_W      = (CNT_BITS > 4) ? CNT_BITS : 4;

    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] MULT_LOAD = MULT_CYCLES[CNT_W-1:0];
    localparam logic [CNT_W-1:0] DIV_LOAD  = DIV_CYCLES[CNT_W-1:0];

    // -------------------------------------------------------------------------
    // Arithmetic helpers
    // -------------------------------------------------------------------------

    // 32x32 -> 64 multiply. Sign-extending both operands to 64 bits and keeping
    // the low 64 bits of the product yields the correct two's-complement result
    // for the signed case and the plain product for the unsigned case.
    function automatic logic [63:0] mul_64(
        input logic [31:0] x,
        input logic [31:0] y,
        input logic        is_signed
    );
        logic [63:0] x_ext;
        logic [63:0] y_ext;
        x_ext  = {{32{is_signed & x[31]}}, x};
        y_ext  = {{32{is_signed & y[31]}}, y};
        mul_64 = x_ext * y_ext;
    endfunction

    // 32-bit divide returning {remainder, quotient}.
    // The signed case divides magnitudes and re-applies signs: the quotient is
    // negative when the operand signs differ (truncation toward zero) and the
    // remainder follows the dividend. The magnitude of 0x80000000 is still
    // 0x80000000 as an unsigned value, so 0x80000000 / -1 naturally yields
    // quotient 0x80000000 and remainder 0 without a special case.
    // A zero divisor returns zeros; the caller never commits that result.
    function automatic logic [63:0] div_64(
        input logic [31:0] x,
        input logic [31:0] y,
        input logic        is_signed
    );
        logic        x_neg;
        logic        y_neg;
        logic [31:0] x_mag;
        logic [31:0] y_mag;
        logic [31:0] q_mag;
        logic [31:0] r_mag;
        logic [31:0] quot;
        logic [31:0] rem;
        x_neg = is_signed & x[31];
        y_neg = is_signed & y[31];
        x_mag = x_neg ? (32'd0 - x) : x;
        y_mag = y_neg ? (32'd0 - y) : y;
        if (y_mag == 32'd0) begin
            q_mag = 32'd0;
            r_mag = 32'd0;
        end else begin
            q_mag = x_mag / y_mag;
            r_mag = x_mag % y_mag;
        end
        quot   = (x_neg ^ y_neg) ? (32'd0 - q_mag) : q_mag;
        rem    = x_neg ? (32'd0 - r_mag) : r_mag;
        div_64 = {rem, quot};
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [31:0]      hi_r;
    logic [31:0]      lo_r;
    logic [31:0]      pend_hi_r;
    logic [31:0]      pend_lo_r;
    logic [CNT_W-1:0] cnt_r;
    logic             busy_r;

    logic [31:0]      hi_nxt_s;
    logic [31:0]      lo_nxt_s;
    logic [31:0]      pend_hi_nxt_s;
    logic [31:0]      pend_lo_nxt_s;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             busy_nxt_s;

    logic             in_flight_s;
    logic             commit_s;
    logic             is_signed_s;
    logic [63:0]      prod_s;
    logic [63:0]      divres_s;

    // Datapath: product and quotient/remainder of the current operands.
    always_comb begin
        is_signed_s = 1'b0;
        case (md_op)
            OP_MULT:  is_signed_s = 1'b1;
            OP_DIV:   is_signed_s = 1'b1;
            OP_NONE,
            OP_MULTU,
            OP_DIVU,
            OP_MTHI,
            OP_MTLO,
            OP_RSVD:  is_signed_s = 1'b0;
            default:  is_signed_s = 1'b0;
        endcase
        prod_s   = mul_64(a, b, is_signed_s);
        divres_s = div_64(a, b, is_signed_s);
    end

    // Sequencing: counter countdown, commit of pending results, and issue
    // decode. Issue is only considered when nothing is in flight, so a start
    // during busy (including the completing cycle) has no effect at all.
    always_comb begin
        hi_nxt_s      = hi_r;
        lo_nxt_s      = lo_r;
        pend_hi_nxt_s = pend_hi_r;
        pend_lo_nxt_s = pend_lo_r;
        cnt_nxt_s     = cnt_r;
        in_flight_s   = (cnt_r != CNT_ZERO);
        commit_s      = (cnt_r == CNT_ONE);

        if (in_flight_s) begin
            cnt_nxt_s = cnt_r - CNT_ONE;
            if (commit_s) begin
                hi_nxt_s = pend_hi_r;
                lo_nxt_s = pend_lo_r;
            end else begin
                hi_nxt_s = hi_r;
                lo_nxt_s = lo_r;
            end
        end else if (start) begin
            case (md_op)
                OP_MULT, OP_MULTU: begin
                    pend_hi_nxt_s = prod_s[63:32];
                    pend_lo_nxt_s = prod_s[31:0];
                    cnt_nxt_s     = MULT_LOAD;
                end
                OP_DIV, OP_DIVU: begin
                    // A zero divisor re-commits the current HI/LO, which is
                    // stable for the whole busy window since nothing else can
                    // be issued meanwhile.
                    if (b != 32'd0) begin
                        pend_hi_nxt_s = divres_s[63:32];
                        pend_lo_nxt_s = divres_s[31:0];
                    end else begin
                        pend_hi_nxt_s = hi_r;
                        pend_lo_nxt_s = lo_r;
                    end
                    cnt_nxt_s = DIV_LOAD;
                end
                OP_MTHI: begin
                    hi_nxt_s = a;
                end
                OP_MTLO: begin
                    lo_nxt_s = a;
                end
                OP_NONE, OP_RSVD: begin
                    cnt_nxt_s = cnt_r;
                end
                default: begin
                    cnt_nxt_s = cnt_r;
                end
            endcase
        end else begin
            cnt_nxt_s = cnt_r;
        end

        // busy is registered but always equals (counter != 0).
        busy_nxt_s = (cnt_nxt_s != CNT_ZERO);
    end

    // State register with asynchronous clear of everything, including results.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_r      <= 32'd0;
            lo_r      <= 32'd0;
            pend_hi_r <= 32'd0;
            pend_lo_r <= 32'd0;
            cnt_r     <= CNT_ZERO;
            busy_r    <= 1'b0;
        end else begin
            hi_r      <= hi_nxt_s;
            lo_r      <= lo_nxt_s;
            pend_hi_r <= pend_hi_nxt_s;
            pend_lo_r <= pend_lo_nxt_s;
            cnt_r     <= cnt_nxt_s;
            busy_r    <= busy_nxt_s;
        end
    end

    // Outputs are driven straight from committed registers.
    assign busy = busy_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: tb/tb_md_unit.sv
// -----------------------------------------------------------------------------
// tb_md_unit -- self-checking bench for md_unit.
// A reference model tracks HI/LO and the completion edge of the in-flight
// operation in terms of absolute edge numbers, computing results with 64-bit
// integer arithmetic. Outputs are compared every cycle, #1 after the edge.
// -----------------------------------------------------------------------------
module tb_md_unit;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    md_unit #(
        .MULT_CYCLES(MULT_N),
        .DIV_CYCLES (DIV_N)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .md_op(md_op),
        .a    (a),
        .b    (b),
        .busy (busy),
        .hi   (hi),
        .lo   (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state.
    int          edge_no   = 0;
    int          done_edge = -1;
    logic [31:0] m_hi      = 32'd0;
    logic [31:0] m_lo      = 32'd0;
    logic [31:0] m_phi     = 32'd0;
    logic [31:0] m_plo     = 32'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Expected {HI, LO} of a mult/div from plain integer arithmetic.
    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] x,
                                               input logic [31:0] y, input logic [31:0] cur_hi,
                                               input logic [31:0] cur_lo);
        longint sx, sy, q, r;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (op)
            3'd1: begin
                q = sx * sy;
                return 64'(q);
            end
            3'd2: begin
                p = {32'd0, x} * {32'd0, y};
                return p;
            end
            3'd3: begin
                if (y == 32'd0) return {cur_hi, cur_lo};
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
            3'd4: begin
                if (y == 32'd0) return {cur_hi, cur_lo};
                return {x % y, x / y};
            end
            default: return {cur_hi, cur_lo};
        endcase
    endfunction

    // Model behaviour at one rising edge with the given inputs.
    task automatic model_edge(input logic s, input logic [2:0] op, input logic [31:0] av,
                              input logic [31:0] bv);
        edge_no++;
        if (edge_no <= done_edge) begin
            if (edge_no == done_edge) begin
                m_hi = m_phi;
                m_lo = m_plo;
            end
        end else if (s) begin
            case (op)
                3'd1, 3'd2: begin
                    {m_phi, m_plo} = ref_result(op, av, bv, m_hi, m_lo);
                    done_edge = edge_no + MULT_N;
                end
                3'd3, 3'd4: begin
                    {m_phi, m_plo} = ref_result(op, av, bv, m_hi, m_lo);
                    done_edge = edge_no + DIV_N;
                end
                3'd5: m_hi = av;
                3'd6: m_lo = av;
                default: ;
            endcase
        end
    endtask

    task automatic model_reset();
        m_hi = 32'd0; m_lo = 32'd0; m_phi = 32'd0; m_plo = 32'd0;
        done_edge = -1;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_busy"}, {31'd0, busy}, {31'd0, (edge_no < done_edge)});
        chk({tag, "_hi"}, hi, m_hi);
        chk({tag, "_lo"}, lo, m_lo);
    endtask

    // One clock: drive at negedge, model at posedge, sample #1 later.
    task automatic step(input logic s, input logic [2:0] op, input logic [31:0] av,
                        input logic [31:0] bv, input string tag);
        @(negedge clk);
        start = s; md_op = op; a = av; b = bv;
        @(posedge clk);
        model_edge(s, op, av, bv);
        #1;
        check_outputs(tag);
    endtask

    // Idle cycles with scrambled operands: late operand changes must not matter.
    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, 3'd0, $urandom, $urandom, tag);
    endtask

    // Asynchronous reset pulse placed between edges.
    task automatic pulse_reset(input string tag);
        @(negedge clk);
        start = 1'b0;
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk({tag, "_async_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_async_hi"}, hi, 32'd0);
        chk({tag, "_async_lo"}, lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    logic [31:0] ra, rb;
    logic [2:0]  rop;

    initial begin
        reset = 1'b0; start = 1'b0; md_op = 3'd0; a = 32'd0; b = 32'd0;
        #1 reset = 1'b1;
        #2;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // First edge after release accepts; signed mult.
        step(1'b1, 3'd1, 32'hFFFF_FFFF, 32'h0000_0002, "mult");
        idle(MULT_N, "mult_wait");
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFE);

        step(1'b1, 3'd2, 32'hFFFF_FFFF, 32'h0000_0002, "multu");
        idle(MULT_N, "multu_wait");
        chk("multu_hi", hi, 32'h0000_0001);
        chk("multu_lo", lo, 32'hFFFF_FFFE);

        step(1'b1, 3'd3, 32'hFFFF_FFF9, 32'h0000_0002, "div");
        idle(DIV_N, "div_wait");
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);

        step(1'b1, 3'd4, 32'd7, 32'd2, "divu");
        idle(DIV_N, "divu_wait");
        chk("divu_lo", lo, 32'd3);
        chk("divu_hi", hi, 32'd1);

        step(1'b1, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, "divovf");
        idle(DIV_N, "divovf_wait");
        chk("divovf_lo", lo, 32'h8000_0000);
        chk("divovf_hi", hi, 32'h0000_0000);

        step(1'b1, 3'd5, 32'h1234_5678, 32'd0, "mthi");
        chk("mthi_hi", hi, 32'h1234_5678);
        step(1'b1, 3'd6, 32'h9ABC_DEF0, 32'd0, "mtlo");
        chk("mtlo_lo", lo, 32'h9ABC_DEF0);
        chk("mtlo_busy", {31'd0, busy}, 32'd0);

        step(1'b1, 3'd6, 32'h0000_0055, 32'd0, "mtlo55");
        step(1'b1, 3'd3, 32'd100, 32'd0, "divz");
        idle(DIV_N, "divz_wait");
        chk("divz_lo", lo, 32'h0000_0055);
        chk("divz_hi", hi, 32'h1234_5678);

        // Reset during the third busy cycle of a mult.
        step(1'b1, 3'd1, 32'd3, 32'd5, "rstmid");
        idle(2, "rstmid_wait");
        pulse_reset("rstmid");
        idle(MULT_N + 2, "rstmid_after");
        chk("rstmid_hi", hi, 32'd0);
        chk("rstmid_lo", lo, 32'd0);

        // divu issued while a mult is in flight is ignored.
        step(1'b1, 3'd1, 32'd3, 32'd5, "ign_mult");
        step(1'b1, 3'd4, 32'd100, 32'd7, "ign_divu");
        idle(MULT_N - 2, "ign_wait");
        chk("ign_busy_last", {31'd0, busy}, 32'd1);
        idle(1, "ign_done");
        chk("ign_busy_off", {31'd0, busy}, 32'd0);
        chk("ign_lo", lo, 32'd15);
        chk("ign_hi", hi, 32'd0);

        // Randomized traffic, including issue while busy and rare resets.
        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(0, 3))
                0: ra = 32'h8000_0000;
                1: ra = $urandom_range(0, 100);
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = $urandom_range(1, 20);
                default: rb = $urandom;
            endcase
            rop = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 199) == 0) pulse_reset("rnd_rst");
            else step($urandom_range(0, 3) != 0, rop, ra, rb, "rnd");
        end
        idle(DIV_N + 1, "rnd_drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 SHALL expose parameter MULT_CYCLES, default 5, busy duration for mult/multu.
REQ-002 SHALL expose parameter DIV_CYCLES, default 10, busy duration for div/divu.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 start  input  1  E-stage issue strobe; md_op sampled when high.
REQ-006 md_op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved.
REQ-007 a  input  32  rs operand (dividend / multiplicand / mthi-mtlo source).
REQ-008 b  input  32  rt operand (divisor / multiplier).
REQ-009 busy  output  1  high while a mult/div is in flight.
REQ-010 hi  output  32  committed HI register, read by mfhi.
REQ-011 lo  output  32  committed LO register, read by mflo.

Function
REQ-012 SHALL hold state: HI, LO, pending-result registers (32 bits each), down-counter (4 bits minimum, wide enough for DIV_CYCLES).
REQ-013 SHALL treat start with md_op 0 or 7 as no operation.
REQ-014 mult/multu accepted at edge t SHALL compute the 64-bit product of a and b (signed/unsigned) into the pending registers at edge t, load counter with MULT_CYCLES.
REQ-015 div/divu accepted at edge t SHALL compute quotient into pending-LO, remainder into pending-HI at edge t, load counter with DIV_CYCLES.
REQ-016 signed div SHALL truncate the quotient toward zero; the remainder SHALL take the sign of the dividend.
REQ-017 signed 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0x00000000.
REQ-018 divisor of zero (div or divu) SHALL leave HI and LO unchanged; busy SHALL still assert for DIV_CYCLES.
REQ-019 busy SHALL equal (counter != 0); busy is high on cycles t+1 .. t+N for an op accepted at edge t, N = configured latency.
REQ-020 counter SHALL decrement by one each edge while nonzero.
REQ-021 at the edge where counter goes 1 -> 0, HI/LO SHALL load the pending values; new values are visible in the first cycle busy is low.
REQ-022 mthi/mtlo accepted at edge t SHALL write a into HI/LO at edge t, with no busy cycle.
REQ-023 start while busy is high SHALL be ignored entirely (no state change); the pipeline stall logic is responsible for never issuing it.
REQ-024 hi/lo outputs SHALL only ever show committed values, never pending values mid-operation.
REQ-025 an mthi/mtlo and the completion of a prior op SHALL never coincide, because REQ-023 excludes issue while busy.
REQ-026 operands a and b SHALL be consumed only at the accepting edge; later changes have no effect.

Reset
REQ-027 on reset assertion, HI=0, LO=0, pending=0, counter=0, busy=0, independent of clk.
REQ-028 reset mid-operation SHALL discard the in-flight result; HI/LO stay 0 after release.
REQ-029 the first edge after reset deassertion SHALL accept a start normally.

Verification
REQ-030 mult a=0xFFFFFFFF, b=0x00000002 -> busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE. multu with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-031 div a=0xFFFFFFF9 (-7), b=2 -> busy high 10 cycles; then LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). divu a=7, b=2 -> LO=3, HI=1.
REQ-032 mthi a=0x12345678 then mtlo a=0x9ABCDEF0 on consecutive cycles -> hi/lo update on each edge; busy never asserts.
REQ-033 div with b=0 after mtlo 0x55 -> busy 10 cycles; LO remains 0x55.
REQ-034 start mult, assert reset at busy cycle 3 -> busy=0, HI=LO=0 immediately; no later update.
REQ-035 start divu while a mult is busy -> ignored; the mult result commits on schedule and busy drops after the original 5 cycles.
